// File: rtl/mul_arbiter_if.sv
// Request, result and multiplier-side signals of mul_arbiter.
// slave is the arbiter's view; master is the clients' plus multiplier's view.
interface mul_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [2*W-1:0]    res_p;
    logic              res_err;
    logic              busy;
    logic [W-1:0]      mul_x;
    logic [W-1:0]      mul_y;
    logic              mul_reset;
    logic [2*W-1:0]    mul_p;
    logic              mul_halt;

    modport slave (
        input  req_valid, req_x, req_y, mul_p, mul_halt,
        output req_ready, res_valid, res_id, res_p, res_err, busy,
               mul_x, mul_y, mul_reset
    );

    modport master (
        output req_valid, req_x, req_y, mul_p, mul_halt,
        input  req_ready, res_valid, res_id, res_p, res_err, busy,
               mul_x, mul_y, mul_reset
    );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin scheduler sharing one sequential signed multiplier among NREQ requesters.
// Define MUL_ARB_TIMEOUT_EN to abort a WAIT that sees no halt within TIMEOUT cycles.
module mul_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    mul_arbiter_if.slave bus
);
    if ((2 ** IDW) < NREQ || TIMEOUT == 0) begin : g_param_check
        $error("mul_arbiter: IDW too narrow for NREQ or TIMEOUT is zero");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] pick_id;
    logic [IDW-1:0] scan_id;
    logic           pick_found;
    logic           accept;
    logic           first_wait;
    logic           halt_ok;
    logic           timed_out;

    // Cyclic scan starting at rr_ptr; first asserted request wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_id = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!pick_found && bus.req_valid[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    assign accept        = (state == IDLE) && pick_found && !reset;
    assign bus.req_ready = accept ? (NREQ'(1) << pick_id) : '0;
    // Halt may still be stale in the first WAIT cycle.
    assign halt_ok       = (state == WAIT) && !first_wait && bus.mul_halt;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = (state == WAIT) && !halt_ok && (wait_cnt == TW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   state_next = WAIT;
            WAIT:    if (halt_ok || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are derived from the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr        <= '0;
            gnt_id        <= '0;
            first_wait    <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_p     <= '0;
            bus.res_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.mul_x     <= '0;
            bus.mul_y     <= '0;
            bus.mul_reset <= 1'b1;
        end else begin
            bus.busy      <= (state_next != IDLE);
            bus.mul_reset <= (state_next == START);
            bus.res_valid <= (state_next == DONE);
            first_wait    <= (state == START);
            if (accept) begin
                gnt_id    <= pick_id;
                bus.mul_x <= bus.req_x[32'(pick_id) * W +: W];
                bus.mul_y <= bus.req_y[32'(pick_id) * W +: W];
            end
            if ((state == WAIT) && (state_next == DONE)) begin
                bus.res_id  <= gnt_id;
                bus.res_p   <= halt_ok ? bus.mul_p : '0;
                bus.res_err <= !halt_ok;
            end
            if (state == DONE) begin
                rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter: a round-robin/scoreboard model predicts grants,
// result timing, ids and products; a behavioural multiplier serves the DUT.
module tb_mul_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned W       = 4;
    localparam int unsigned IDW     = 2;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned PW      = 2 * W;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mul_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bus ();

    mul_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Requester-side state
    logic [NREQ-1:0] rv;
    logic [W-1:0]    rx [NREQ];
    logic [W-1:0]    ry [NREQ];
    bit              persist;
    bit              rnd_mode;

    // Multiplier model controls
    bit              halt_en;
    int unsigned     mul_lat;
    int unsigned     mcnt;

    // Reference model state
    int              ptr;
    bit              inflight;
    bit              start_next;
    int              cyc;
    int              q_id  [$];
    logic [PW-1:0]   q_p   [$];
    bit              q_err [$];
    int              q_cyc [$];
    logic [IDW-1:0]  last_id;
    logic [PW-1:0]   last_p;

    function automatic logic [PW-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        ia = int'($signed(a));
        ib = int'($signed(b));
        return PW'(ia * ib);
    endfunction

    // Sequential multiplier: restarts on mul_reset, raises halt mul_lat cycles later.
    always @(posedge clk) begin
        if (bus.mul_reset) begin
            mcnt         <= 0;
            bus.mul_halt <= 1'b0;
            bus.mul_p    <= '0;
        end else if (!bus.mul_halt && halt_en) begin
            if (mcnt == mul_lat) begin
                bus.mul_halt <= 1'b1;
                bus.mul_p    <= smul(bus.mul_x, bus.mul_y);
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'(0));
        check({tag, " res_valid"}, 32'(bus.res_valid), 32'(0));
        check({tag, " res_id"},    32'(bus.res_id),    32'(0));
        check({tag, " res_p"},     32'(bus.res_p),     32'(0));
        check({tag, " res_err"},   32'(bus.res_err),   32'(0));
        check({tag, " busy"},      32'(bus.busy),      32'(0));
        check({tag, " mul_x"},     32'(bus.mul_x),     32'(0));
        check({tag, " mul_y"},     32'(bus.mul_y),     32'(0));
        check({tag, " mul_reset"}, 32'(bus.mul_reset), 32'(1));
    endtask

    // Asserts reset mid-cycle (away from clk edges), then clears the model.
    task automatic apply_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        bus.req_valid = '1;
        #1;
        check_reset_vals("rst_async");
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst_held");
        rv = '0;
        bus.req_valid = '0;
        reset = 1'b0;
        ptr        = 0;
        inflight   = 1'b0;
        start_next = 1'b0;
        last_id    = '0;
        last_p     = '0;
        q_id.delete();
        q_p.delete();
        q_err.delete();
        q_cyc.delete();
    endtask

    // One clock cycle: drive requesters, predict and compare, advance the model.
    task automatic step();
        int              g;
        int              idx;
        logic [NREQ-1:0] exp_rdy;
        bit              exp_rv;
        @(negedge clk);
        bus.req_valid = rv;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*W +: W] = rx[i];
            bus.req_y[i*W +: W] = ry[i];
        end
        #1;
        g = -1;
        if (!inflight) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (ptr + k) % NREQ;
                if (g < 0 && rv[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("busy",      32'(bus.busy),      32'(inflight));
        check("mul_reset", 32'(bus.mul_reset), 32'(start_next));

        exp_rv = (q_cyc.size() > 0) && (q_cyc[0] == cyc);
        check("res_valid", 32'(bus.res_valid), 32'(exp_rv));
        if (exp_rv) begin
            last_id = IDW'(q_id[0]);
            last_p  = q_p[0];
            check("res_err", 32'(bus.res_err), 32'(q_err[0]));
            ptr      = (q_id[0] + 1) % NREQ;
            inflight = 1'b0;
            void'(q_id.pop_front());
            void'(q_p.pop_front());
            void'(q_err.pop_front());
            void'(q_cyc.pop_front());
        end
        check("res_id", 32'(bus.res_id), 32'(last_id));
        check("res_p",  32'(bus.res_p),  32'(last_p));

        start_next = 1'b0;
        if (g >= 0) begin
            start_next = 1'b1;
            inflight   = 1'b1;
            if (rnd_mode) mul_lat = $urandom_range(0, 5);
            q_id.push_back(g);
            if (halt_en) begin
                q_p.push_back(smul(rx[g], ry[g]));
                q_err.push_back(1'b0);
                q_cyc.push_back(cyc + 4 + int'(mul_lat));
            end else begin
                q_p.push_back('0);
                q_err.push_back(1'b1);
`ifdef MUL_ARB_TIMEOUT_EN
                q_cyc.push_back(cyc + 2 + int'(TIMEOUT));
`else
                q_cyc.push_back(-1);
`endif
            end
            if (persist || (rnd_mode && $urandom_range(0, 1) == 1)) begin
                rx[g] = W'($urandom);
                ry[g] = W'($urandom);
            end else begin
                rv[g] = 1'b0;
            end
        end
        if (rnd_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (i != g && $urandom_range(0, 3) == 0) begin
                    rv[i] = ~rv[i];
                    rx[i] = W'($urandom);
                    ry[i] = W'($urandom);
                end
            end
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [W-1:0] ex_x [3];
        logic [W-1:0] ex_y [3];
        reset         = 1'b1;
        rv            = '0;
        persist       = 1'b0;
        rnd_mode      = 1'b0;
        halt_en       = 1'b1;
        mul_lat       = 3;
        cyc           = 0;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        for (int i = 0; i < NREQ; i++) begin
            rx[i] = '0;
            ry[i] = '0;
        end
        apply_reset();

        // Single request: -5 * -6
        rx[0] = 4'b1011;
        ry[0] = 4'b1010;
        rv[0] = 1'b1;
        run(14);

        // Operand extremes
        ex_x = '{4'h8, 4'h8, 4'h0};
        ex_y = '{4'h8, 4'h7, 4'hF};
        for (int i = 0; i < 3; i++) begin
            rx[0] = ex_x[i];
            ry[0] = ex_y[i];
            rv[0] = 1'b1;
            run(12);
        end

        // All requesters continuously valid from a fresh pointer
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b1;
            rx[i] = W'(i + 1);
            ry[i] = W'(7 - 3 * i);
        end
        persist = 1'b1;
        run(45);
        persist = 1'b0;
        run(40);

        // Fairness: serve 2, then 1 and 2 compete
        rv[2] = 1'b1;
        run(12);
        rv[1] = 1'b1;
        rv[2] = 1'b1;
        run(25);

        // Reset during WAIT after serving 1, then 3 and 0 compete
        rv[1] = 1'b1;
        run(12);
        mul_lat = 8;
        rv[2] = 1'b1;
        run(3);
        apply_reset();
        mul_lat = 3;
        rv[3] = 1'b1;
        rv[0] = 1'b1;
        run(25);

        // Multiplier never halts
        halt_en = 1'b0;
        rv[0] = 1'b1;
        run(40);
        apply_reset();
        halt_en = 1'b1;

        // Random traffic
        rnd_mode = 1'b1;
        run(400);
        rnd_mode = 1'b0;
        rv = '0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
